// File: rtl/muldiv_pkg.sv
// Shared constants, opcode and state encodings for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_LAST  = 31;
  localparam int ALU_W     = 16;
  localparam int ALU_MULT  = 12;
  localparam int ALU_MULTU = 13;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  function automatic logic [XLEN-1:0] mag(
    input logic [XLEN-1:0] v,
    input logic            sgn
  );
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring divider on operand magnitudes, one quotient bit per step, MSB first.
module div_iter
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem,
  output logic            last
);

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] trial;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = {1'b0, shifted} - {2'b00, dvs_q};
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = '0;
    end else if (step) begin
      // Negative trial means restore: keep the shifted remainder, emit 0.
      rem_d = trial[XLEN+1] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], ~trial[XLEN+1]};
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quo  = quo_q;
  assign rem  = rem_q;
  assign last = (cnt_q == 5'(DIV_LAST));

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO controller: MUL via the shared ALU, DIV via the iterative divider.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_src1,
  input  logic [XLEN-1:0]  req_src2,
  output logic             req_ready,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  hi_rdata,
  output logic [XLEN-1:0]  lo_rdata,
  output logic [ALU_W-1:0] alu_op,
  output logic [XLEN-1:0]  alu_src1,
  output logic [XLEN-1:0]  alu_src2,
  input  logic [XLEN-1:0]  alu_hi,
  input  logic [XLEN-1:0]  alu_result
);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic             done_q, done_d;
  logic [ALU_W-1:0] alu_op_q, alu_op_d;
  logic [XLEN-1:0]  src1_q, src1_d;
  logic [XLEN-1:0]  src2_q, src2_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             div_start;
  logic             div_step;
  logic             div_sgn;
  logic [XLEN-1:0]  div_quo;
  logic [XLEN-1:0]  div_rem;
  logic             div_last;

  assign div_sgn  = (req_op == OP_DIV);
  assign div_step = (state_q == S_DIV) && !flush;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    alu_op_d  = '0;
    src1_d    = src1_q;
    src2_d    = src2_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    div_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          case (req_op)
            OP_MULT, OP_MULTU: begin
              src1_d  = req_src1;
              src2_d  = req_src2;
              state_d = S_MUL;
              if (req_op == OP_MULT) alu_op_d[ALU_MULT] = 1'b1;
              else                   alu_op_d[ALU_MULTU] = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              src1_d    = req_src1;
              src2_d    = req_src2;
              negq_d    = div_sgn & (req_src1[XLEN-1] ^ req_src2[XLEN-1]);
              negr_d    = div_sgn & req_src1[XLEN-1];
              div_start = 1'b1;
              state_d   = S_DIV;
            end
            OP_MTHI: hi_d = req_src1;
            OP_MTLO: lo_d = req_src1;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        state_d = S_IDLE;
        if (!flush) begin
          hi_d   = alu_hi;
          lo_d   = alu_result;
          done_d = 1'b1;
        end
      end
      S_DIV: begin
        if (flush)         state_d = S_IDLE;
        else if (div_last) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          lo_d   = negq_q ? -div_quo : div_quo;
          hi_d   = negr_q ? -div_rem : div_rem;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      alu_op_q <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      alu_op_q <= alu_op_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

  div_iter u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .step     (div_step),
    .dividend (mag(req_src1, div_sgn)),
    .divisor  (mag(req_src2, div_sgn)),
    .quo      (div_quo),
    .rem      (div_rem),
    .last     (div_last)
  );

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign hi_rdata  = hi_q;
  assign lo_rdata  = lo_q;
  assign alu_op    = alu_op_q;
  assign alu_src1  = src1_q;
  assign alu_src2  = src2_q;

endmodule
